// File: rtl/aes_cipher_iter_if.sv
// Handshake/data bundle between the iterative AES forward cipher and its block/key source.
// Optional macro AES_CIPHER_KEYVALID_EN adds the key_valid qualifier.
interface aes_cipher_iter_if;
  logic [0:127] data;
  logic [0:1]   mode;
  logic         start;
  logic [0:127] round_key;
  logic [3:0]   round_idx;
  logic [0:127] result;
  logic         busy;
  logic         done;
`ifdef AES_CIPHER_KEYVALID_EN
  logic         key_valid;

  modport master (output data, mode, start, round_key, key_valid,
                  input  round_idx, result, busy, done);
  modport slave  (input  data, mode, start, round_key, key_valid,
                  output round_idx, result, busy, done);
`else
  modport master (output data, mode, start, round_key,
                  input  round_idx, result, busy, done);
  modport slave  (input  data, mode, start, round_key,
                  output round_idx, result, busy, done);
`endif
endinterface

// File: rtl/aes_cipher_iter.sv
// Iterative AES-128/192/256 forward cipher, one round per clock, round keys fetched by index.
// Optional macro AES_CIPHER_KEYVALID_EN: key_valid gates start acceptance and round progress.
module aes_cipher_iter #(
  parameter int NR_MAX = 14
) (
  input logic              clk_i,
  input logic              rst_n_i,
  aes_cipher_iter_if.slave bus
);
  localparam int CW = $clog2(NR_MAX + 1);
  localparam logic [1:0] S_IDLE = 2'd0, S_ROUND = 2'd1, S_DONE = 2'd2;

  localparam logic [0:2047] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};

  logic [1:0]    fsm_q, fsm_d;
  logic [0:127]  state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d, nr_q, nr_d, nr_sel;
  logic          busy_q, busy_d, done_q, done_d;
  logic          kv;
  logic [0:127]  sb, sr, mc, rnd;

`ifdef AES_CIPHER_KEYVALID_EN
  assign kv = bus.key_valid;
`else
  assign kv = 1'b1;
`endif

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [31:0] mixcol(input logic [31:0] c);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = c;
    return {xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3,
            a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3,
            a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3,
            xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3)};
  endfunction

  // One SubBytes/ShiftRows layer; the final round just skips MixColumns via the mux.
  always_comb begin
    sb = '0;
    sr = '0;
    mc = '0;
    for (int j = 0; j < 16; j++)
      sb[8*j +: 8] = SBOX[{state_q[8*j +: 8], 3'b000} +: 8];
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        sr[8*(4*c+r) +: 8] = sb[8*(4*((c+r)%4)+r) +: 8];
    for (int c = 0; c < 4; c++)
      mc[32*c +: 32] = mixcol(sr[32*c +: 32]);
    rnd = ((cnt_q == nr_q) ? sr : mc) ^ bus.round_key;
  end

  always_comb begin
    case (bus.mode)
      2'd0:    nr_sel = CW'(10);
      2'd1:    nr_sel = CW'(12);
      default: nr_sel = CW'(14);
    endcase
  end

  always_comb begin
    fsm_d   = fsm_q;
    state_d = state_q;
    cnt_d   = cnt_q;
    nr_d    = nr_q;
    busy_d  = busy_q;
    done_d  = done_q;
    case (fsm_q)
      S_IDLE, S_DONE: begin
        if (bus.start && kv) begin
          state_d = bus.data ^ bus.round_key;
          nr_d    = nr_sel;
          cnt_d   = CW'(1);
          done_d  = 1'b0;
          busy_d  = 1'b1;
          fsm_d   = S_ROUND;
        end
      end
      S_ROUND: begin
        if (kv) begin
          state_d = rnd;
          if (cnt_q == nr_q) begin
            // counter back to 0 so the next start picks up round key 0
            cnt_d  = '0;
            busy_d = 1'b0;
            done_d = 1'b1;
            fsm_d  = S_DONE;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      default: fsm_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      fsm_q   <= S_IDLE;
      state_q <= '0;
      cnt_q   <= '0;
      nr_q    <= CW'(10);
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      fsm_q   <= fsm_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      nr_q    <= nr_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bus.round_idx = 4'(cnt_q);
  assign bus.result    = done_q ? state_q : '0;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
endmodule

// File: tb/tb_aes_cipher_iter.sv
// Directed bench for aes_cipher_iter: bench-side key expansion feeds round keys, scoreboard checks ciphertext.
module tb_aes_cipher_iter;
  logic clk = 1'b0;
  logic rst_n;
  int   tests = 0;
  int   fails = 0;

  localparam logic [0:127] PT   = 128'h00112233445566778899aabbccddeeff;
  localparam logic [0:127] C128 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [0:127] C192 = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
  localparam logic [0:127] C256 = 128'h8ea2b7ca516745bfeafc49904b496089;

  logic [0:127] rk [0:15];
  logic [0:127] exp_q [$];

  aes_cipher_iter_if bus ();
  aes_cipher_iter #(.NR_MAX(14)) dut (.clk_i(clk), .rst_n_i(rst_n), .bus(bus));

  assign bus.round_key = rk[bus.round_idx];

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    for (int k = 0; k < 8; k++) begin
      if (b[0]) p ^= a;
      a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
      b = b >> 1;
    end
    return p;
  endfunction

  // S-box from first principles: GF inverse (x^254) followed by the affine map.
  function automatic logic [7:0] sbox_f(input logic [7:0] x);
    logic [7:0] r = 8'h01, b = x, y, s;
    logic [7:0] e = 8'd254;
    for (int k = 0; k < 8; k++) begin
      if (e[k]) r = gmul(r, b);
      b = gmul(b, b);
    end
    s = r;
    y = r;
    for (int n = 0; n < 4; n++) begin
      y = {y[6:0], y[7]};
      s ^= y;
    end
    return s ^ 8'h63;
  endfunction

  function automatic logic [31:0] subw(input logic [31:0] w);
    return {sbox_f(w[31:24]), sbox_f(w[23:16]), sbox_f(w[15:8]), sbox_f(w[7:0])};
  endfunction

  // Key bytes are 00,01,02,... for every key size in the vectors used here.
  task automatic expand(input int nk);
    logic [31:0] w [0:59];
    logic [31:0] t;
    logic [7:0]  rc = 8'h01;
    int nr = nk + 6;
    for (int i = 0; i < nk; i++)
      w[i] = {8'(4*i), 8'(4*i+1), 8'(4*i+2), 8'(4*i+3)};
    for (int i = nk; i < 4*(nr+1); i++) begin
      t = w[i-1];
      if (i % nk == 0) begin
        t  = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        rc = gmul(rc, 8'h02);
      end else if (nk > 6 && i % nk == 4) begin
        t = subw(t);
      end
      w[i] = w[i-nk] ^ t;
    end
    for (int r = 0; r < 16; r++)
      rk[r] = (r <= nr) ? {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]} : '0;
  endtask

  // Runs one block; called #1 after a rising edge. inject pokes ignored starts,
  // stall_at>0 drops key_valid for 3 cycles once round_idx reaches that value.
  task automatic run(input logic [0:127] d, input logic [1:0] m, input logic [0:127] exp,
                     input int exp_lat, input bit inject, input int stall_at);
    int cyc = 0, exp_idx = 1, idx_bad = 0, stall_left = 3;
    bit kv;
    check("idx_before_start", 128'(bus.round_idx), 128'd0);
    bus.data  = d;
    bus.mode  = m;
    bus.start = 1'b1;
    exp_q.push_back(exp);
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.data  = ~d;
    bus.mode  = m ^ 2'b01;
    check("done_drops", 128'(bus.done), 128'd0);
    check("busy_rises", 128'(bus.busy), 128'd1);
    while (!bus.done && cyc < 40) begin
      if (bus.round_idx !== 4'(exp_idx)) idx_bad++;
      kv = 1'b1;
      if (stall_at > 0 && exp_idx == stall_at && stall_left > 0) begin
        kv = 1'b0;
        stall_left--;
      end
`ifdef AES_CIPHER_KEYVALID_EN
      bus.key_valid = kv;
`endif
      if (inject && (cyc == 3 || cyc == 7)) begin
        bus.start = 1'b1;
        bus.data  = 128'hdeadbeef_0badf00d_cafebabe_12345678;
        bus.mode  = 2'd2;
      end else begin
        bus.start = 1'b0;
      end
      @(posedge clk); #1;
      cyc++;
      if (kv) exp_idx++;
    end
    bus.start = 1'b0;
`ifdef AES_CIPHER_KEYVALID_EN
    bus.key_valid = 1'b1;
`endif
    check("latency", 128'(cyc), 128'(exp_lat));
    check("idx_seq_errors", 128'(idx_bad), 128'd0);
    check("busy_clear", 128'(bus.busy), 128'd0);
    check("idx_after_done", 128'(bus.round_idx), 128'd0);
    check("sb_depth", 128'(exp_q.size()), 128'd1);
    if (exp_q.size() > 0) check("result", bus.result, exp_q.pop_front());
  endtask

  initial begin
    rst_n     = 1'b0;
    bus.start = 1'b0;
    bus.data  = '0;
    bus.mode  = 2'd0;
`ifdef AES_CIPHER_KEYVALID_EN
    bus.key_valid = 1'b1;
`endif
    for (int r = 0; r < 16; r++) rk[r] = '0;
    #3;
    check("rst_busy", 128'(bus.busy), 128'd0);
    check("rst_done", 128'(bus.done), 128'd0);
    check("rst_result", bus.result, 128'd0);
    check("rst_idx", 128'(bus.round_idx), 128'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    check("idle_done", 128'(bus.done), 128'd0);

    expand(4);
    run(PT, 2'd0, C128, 10, 1'b0, 0);
    repeat (3) @(posedge clk);
    #1;
    check("done_hold", 128'(bus.done), 128'd1);
    check("result_hold", bus.result, C128);

    expand(6);
    run(PT, 2'd1, C192, 12, 1'b0, 0);
    expand(8);
    run(PT, 2'd2, C256, 14, 1'b0, 0);
    run(PT, 2'd3, C256, 14, 1'b0, 0);

    expand(4);
    run(PT, 2'd0, C128, 10, 1'b1, 0);
    run(PT, 2'd0, C128, 10, 1'b0, 0);

    // Abort an AES-256 run with an asynchronous reset pulse.
    expand(8);
    bus.data  = PT;
    bus.mode  = 2'd2;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (4) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("abort_busy", 128'(bus.busy), 128'd0);
    check("abort_done", 128'(bus.done), 128'd0);
    check("abort_result", bus.result, 128'd0);
    check("abort_idx", 128'(bus.round_idx), 128'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    run(PT, 2'd2, C256, 14, 1'b0, 0);

`ifdef AES_CIPHER_KEYVALID_EN
    expand(4);
    run(PT, 2'd0, C128, 13, 1'b0, 4);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/aes_cipher_iter.md
Name: aes_cipher_iter

Overview:
- Iterative AES forward cipher (encryption) for FIPS-197 AES-128/192/256, selected per block by mode.
- Processes one round per clock and takes each round key from an external key-schedule source through a round-index request.
- Sits beside the inverse cipher in the AES datapath and shares the same key-schedule source and big-endian [0:127] bit ordering (bit 0 = MSB of byte 0).

Parameters:
- NR_MAX, 14, maximum round count; sizes the round counter (4 bits).

Ports:
- Clk  input  1  rising-edge clock.
- Reset  input  1  asynchronous reset, active-low.
- data  input  [0:127]  plaintext; sampled only on an accepted start.
- mode  input  [0:1]  key size: 0 = AES-128 (Nr=10), 1 = AES-192 (Nr=12), 2 or 3 = AES-256 (Nr=14); sampled on an accepted start.
- start  input  1  request to encrypt data.
- RoundKey  input  [0:127]  round key for the index on RoundIdx; combinational, valid the same cycle.
- RoundIdx  output  [3:0]  index of the round key consumed this cycle.
- Result  output  [0:127]  ciphertext; valid while done=1.
- busy  output  1  high while rounds are in progress.
- done  output  1  high from completion until the next accepted start or reset.

Behaviour:
- Reset values (async, Reset=0): state register 0, round counter 0, Nr register 10, FSM in IDLE, busy=0, done=0, Result=0, RoundIdx=0.
- FSM states are IDLE, ROUND, DONE.
- Round counter: RoundIdx always equals the round counter.
- IDLE or DONE, start=1 (accepted start):
  - state <= data ^ RoundKey (RoundIdx=0).
  - Nr latched from mode.
  - counter <= 1, done <= 0, busy <= 1, go to ROUND.
- IDLE or DONE, start=0: hold. In DONE, Result and done stay unchanged.
- ROUND, counter < Nr (full round):
  - state <= MixColumns(ShiftRows(SubBytes(state))) ^ RoundKey.
  - counter++.
- ROUND, counter == Nr (final round):
  - state <= ShiftRows(SubBytes(state)) ^ RoundKey.
  - busy <= 0, done <= 1, go to DONE.
  - Counter resets to 0 at this edge, so RoundIdx=0 again and the next start can sample round key 0.
- Latency: start sampled at edge E0 gives done=1 and valid Result after edge E_Nr (10/12/14 cycles). Back-to-back throughput is one block per Nr+1 cycles; a start is accepted in the DONE-state cycle.
- start while busy=1 is ignored. data and mode changes mid-operation have no effect.
- mode changes after start do not alter Nr for the block in flight.
- Reset asserted mid-operation aborts immediately to reset values. No partial Result is ever exposed, because Result is driven 0 unless done=1.
- Result = state when done=1, else 0.
- Arithmetic:
  - SubBytes uses the forward S-box.
  - MixColumns is GF(2^8) multiplication by {02,03,01,01} rotated, reduction polynomial 0x11B.
  - All XORs are 128-bit, byte j = bits [8j:8j+7].
- Datapath: a single shared SubBytes/ShiftRows instance; the MixColumns output is bypassed by a mux on the final round. No duplicate S-box bank is permitted.

Optional Feature:
- Macro: AES_CIPHER_KEYVALID_EN.
- Defined:
  - Adds input KeyValid (1 bit).
  - A start is accepted only when start=1 and KeyValid=1.
  - In ROUND, the state and counter update only when KeyValid=1; otherwise everything holds and RoundIdx stays stable.
  - Latency grows by one cycle per stalled cycle.
- Undefined: no KeyValid port; RoundKey is always treated as valid, with timing as above.

Test Plan:
- AES-128:
  - Stimulus: key 000102030405060708090a0b0c0d0e0f, data 00112233445566778899aabbccddeeff, mode=0, start pulse; bench supplies round keys indexed by RoundIdx.
  - Response: done rises exactly 10 cycles after the start edge, Result=69c4e0d86a7b0430d8cdb78070b4c55a.
- AES-192:
  - Stimulus: key 000102…1617, same data, mode=1.
  - Response: done after 12 cycles, Result=dda97ca4864cdfe06eaf70a0ec0d7191.
- AES-256:
  - Stimulus: key 000102…1e1f, same data, mode=2, then repeat with mode=3.
  - Response: done after 14 cycles, Result=8ea2b7ca516745bfeafc49904b496089 both times.
- Busy/ignore:
  - Stimulus: start AES-128 vector, then assert start with different data and mode at cycles 3 and 7.
  - Response: ignored; Result still 69c4…c55a at cycle 10. Next start in DONE is accepted, done drops the following cycle, and RoundIdx sequence is 0,1,…,10.
- Reset mid-operation:
  - Stimulus: Reset low for 1 cycle at cycle 5 of an AES-256 run.
  - Response: busy=0, done=0, Result=0, RoundIdx=0 immediately (asynchronous); a subsequent clean run yields 8ea2…6089.
- With AES_CIPHER_KEYVALID_EN:
  - Stimulus: AES-128 vector with KeyValid low for 3 cycles at round 4.
  - Response: RoundIdx held at 4 during the stall, done after 13 cycles, Result=69c4…c55a.
